gray_decoder: RTL and testbench

Receiving end of the Gray-count interface driven by `gray_counter`. Samples a Gray-coded count, optionally resynchronises it, decodes it to binary and checks that successive samples only hold or advance by one modulo 2^WIDTH. Sequence violations are flagged and counted. Used wherever a Gray count crosses into a consumer domain, such as FIFO pointer readers and position monitors.

---
 rtl/gray_decoder.sv | 160 ++++++++++++++++
 tb/tb_gray_decoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder.sv
// Gray-count receiver: captures a Gray count, decodes it to binary and flags and counts illegal steps.
// Define GRAY_DECODER_SYNC_EN to add a two-flop resynchroniser in front of the decoder.
module gray_decoder #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             adv,
   output logic             wrap,
   output logic             step_err,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } state_t;

`ifdef GRAY_DECODER_SYNC_EN
   localparam int FILL = 3;
`else
   localparam int FILL = 1;
`endif

   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = '0;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (v == '1) ? v : v + ERR_W'(1);
   endfunction

   logic [WIDTH-1:0] g_q, g_d;
   logic [FILL-1:0]  fill_q, fill_d;
`ifdef GRAY_DECODER_SYNC_EN
   logic [WIDTH-1:0] g_s1_q, g_s1_d;
   logic [WIDTH-1:0] g_s2_q, g_s2_d;
`endif
   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic [WIDTH-1:0] bin_out_q, bin_out_d;
   logic             bin_valid_q, bin_valid_d;
   logic             adv_q, adv_d;
   logic             wrap_q, wrap_d;
   logic             step_err_q, step_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0] dec_g;
   logic [WIDTH-1:0] dec_bin;
   logic [WIDTH-1:0] delta;
   logic             dec_vld;

   // fill_q marks which capture/sync stages hold a genuine post-reset sample
   always_comb begin
      g_d    = gray_in;
      fill_d = (fill_q << 1) | FILL'(1);
`ifdef GRAY_DECODER_SYNC_EN
      g_s1_d = g_q;
      g_s2_d = g_s1_q;
      dec_g  = g_s2_q;
`else
      dec_g  = g_q;
`endif
      dec_vld = fill_q[FILL-1];
      dec_bin = gray_to_bin(dec_g);
      delta   = dec_bin - prev_bin_q;
   end

   always_comb begin
      state_d     = state_q;
      prev_bin_d  = prev_bin_q;
      bin_out_d   = dec_bin;
      bin_valid_d = bin_valid_q;
      adv_d       = 1'b0;
      wrap_d      = 1'b0;
      step_err_d  = 1'b0;
      err_cnt_d   = err_cnt_q;

      if (clr) begin
         state_d     = ST_ACQUIRE;
         prev_bin_d  = '0;
         bin_valid_d = 1'b0;
         err_cnt_d   = '0;
      end else if (dec_vld) begin
         case (state_q)
            ST_ACQUIRE: begin
               prev_bin_d  = dec_bin;
               bin_valid_d = 1'b1;
               state_d     = ST_TRACK;
            end
            ST_TRACK: begin
               if (delta == WIDTH'(1)) begin
                  adv_d      = 1'b1;
                  wrap_d     = (prev_bin_q == '1);
                  prev_bin_d = dec_bin;
               end else if (delta != '0) begin
                  // resync on the bad value so one glitch costs at most two errors
                  step_err_d = 1'b1;
                  err_cnt_d  = sat_inc(err_cnt_q);
                  prev_bin_d = dec_bin;
               end
            end
            default: state_d = ST_ACQUIRE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_q         <= '0;
         fill_q      <= '0;
`ifdef GRAY_DECODER_SYNC_EN
         g_s1_q      <= '0;
         g_s2_q      <= '0;
`endif
         state_q     <= ST_ACQUIRE;
         prev_bin_q  <= '0;
         bin_out_q   <= '0;
         bin_valid_q <= 1'b0;
         adv_q       <= 1'b0;
         wrap_q      <= 1'b0;
         step_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         g_q         <= g_d;
         fill_q      <= fill_d;
`ifdef GRAY_DECODER_SYNC_EN
         g_s1_q      <= g_s1_d;
         g_s2_q      <= g_s2_d;
`endif
         state_q     <= state_d;
         prev_bin_q  <= prev_bin_d;
         bin_out_q   <= bin_out_d;
         bin_valid_q <= bin_valid_d;
         adv_q       <= adv_d;
         wrap_q      <= wrap_d;
         step_err_q  <= step_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bin_out   = bin_out_q;
   assign bin_valid = bin_valid_q;
   assign adv       = adv_q;
   assign wrap      = wrap_q;
   assign step_err  = step_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder (WIDTH=4, ERR_W=2): directed vector table, corner sequences and random stream vs. a queue model.
module tb_gray_decoder;

   localparam int W    = 4;
   localparam int EW   = 2;
   localparam int MAXE = (1 << EW) - 1;
   localparam int MOD  = 1 << W;
`ifdef GRAY_DECODER_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic [W-1:0]  gray_in = '0;
   logic [W-1:0]  bin_out;
   logic          bin_valid, adv, wrap, step_err;
   logic [EW-1:0] err_cnt;

   int total = 0;
   int bad = 0;

   gray_decoder #(.WIDTH(W), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr(clr),
      .bin_out(bin_out), .bin_valid(bin_valid), .adv(adv), .wrap(wrap),
      .step_err(step_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] gc(input int n);
      int m;
      m = n % MOD;
      return W'(m ^ (m >> 1));
   endfunction

   // inverse Gray by search: the value whose Gray code matches
   function automatic int g2b(input int g);
      for (int v = 0; v < MOD; v++) if ((v ^ (v >> 1)) == g) return v;
      return -1;
   endfunction

   // Reference model: samples in flight are a queue of LAT-1 entries
   int m_q[$];
   bit m_trk = 0;
   int m_prev = 0;
   int e_bin = 0, e_val = 0, e_adv = 0, e_wrap = 0, e_err = 0, e_cnt = 0;

   always @(posedge clk) begin
      int b, d;
      bit have;
      if (!rst_n) begin
         m_q.delete();
         m_trk = 0; m_prev = 0;
         e_bin = 0; e_val = 0; e_adv = 0; e_wrap = 0; e_err = 0; e_cnt = 0;
      end else begin
         have = (m_q.size() == LAT - 1);
         b = have ? g2b(m_q[0]) : 0;
         e_bin = b; e_adv = 0; e_wrap = 0; e_err = 0;
         if (clr) begin
            e_cnt = 0; e_val = 0; m_trk = 0; m_prev = 0;
         end else if (have) begin
            if (!m_trk) begin
               m_prev = b; e_val = 1; m_trk = 1;
            end else begin
               d = (b - m_prev + MOD) % MOD;
               if (d == 1) begin
                  e_adv = 1; e_wrap = (m_prev == MOD - 1) ? 1 : 0; m_prev = b;
               end else if (d != 0) begin
                  e_err = 1; e_cnt = (e_cnt < MAXE) ? e_cnt + 1 : MAXE; m_prev = b;
               end
            end
         end
         m_q.push_back(int'(gray_in));
         if (m_q.size() > LAT - 1) void'(m_q.pop_front());
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic [W-1:0] g, input logic c, input logic r);
      gray_in = g; clr = c; rst_n = r;
      @(posedge clk);
      #1;
      chk("model bin_out", 32'(bin_out), 32'(e_bin));
      chk("model bin_valid", 32'(bin_valid), 32'(e_val));
      chk("model adv", 32'(adv), 32'(e_adv));
      chk("model wrap", 32'(wrap), 32'(e_wrap));
      chk("model step_err", 32'(step_err), 32'(e_err));
      chk("model err_cnt", 32'(err_cnt), 32'(e_cnt));
      @(negedge clk);
   endtask

   typedef struct {
      logic [W-1:0]  g;
      logic [W-1:0]  b;
      logic          a;
      logic          w;
      logic          e;
      logic [EW-1:0] n;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int b, input bit a, input bit w, input bit e, input int n);
      tbl.push_back('{gc(b), W'(b), a, w, e, EW'(n)});
   endtask

   task automatic tbl_chk(input int j);
      chk("tbl bin_out", 32'(bin_out), 32'(tbl[j].b));
      chk("tbl bin_valid", 32'(bin_valid), 32'd1);
      chk("tbl adv", 32'(adv), 32'(tbl[j].a));
      chk("tbl wrap", 32'(wrap), 32'(tbl[j].w));
      chk("tbl step_err", 32'(step_err), 32'(tbl[j].e));
      chk("tbl err_cnt", 32'(err_cnt), 32'(tbl[j].n));
   endtask

   initial begin
      int cur, r;

      // sample 0 acquires, then a full count with wrap, hold, and illegal steps
      add(0, 0, 0, 0, 0);
      for (int b = 1; b < MOD; b++) add(b, 1, 0, 0, 0);
      add(0, 1, 1, 0, 0);
      for (int b = 1; b <= 4; b++) add(b, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(4, 0, 0, 0, 0);
      add(5, 1, 0, 0, 0);
      add(2, 0, 0, 1, 1);
      add(7, 0, 0, 1, 2);
      add(6, 0, 0, 1, 3);
      add(7, 1, 0, 0, 3);
      add(0, 0, 0, 1, 3);
      add(10, 0, 0, 1, 3);

      cyc('0, 0, 0);
      cyc('0, 0, 0);
      chk("reset bin_out", 32'(bin_out), 32'd0);
      chk("reset bin_valid", 32'(bin_valid), 32'd0);
      chk("reset err_cnt", 32'(err_cnt), 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].g, 0, 1);
         if (i - (LAT - 1) >= 0) tbl_chk(i - (LAT - 1));
      end
      for (int k = 0; k < LAT - 1; k++) begin
         cyc(tbl[tbl.size()-1].g, 0, 1);
         tbl_chk(tbl.size() - (LAT - 1) + k);
      end

      // clr lands on the edge that decodes an illegal step (10 -> 9)
      cyc(gc(9), 0, 1);
      for (int k = 0; k < LAT - 2; k++) cyc(gc(9), 0, 1);
      cyc(gc(9), 1, 1);
      chk("clr step_err", 32'(step_err), 32'd0);
      chk("clr err_cnt", 32'(err_cnt), 32'd0);
      chk("clr bin_valid", 32'(bin_valid), 32'd0);
      cyc(gc(2), 0, 1);
      chk("reacq bin_valid", 32'(bin_valid), 32'd1);
      chk("reacq step_err", 32'(step_err), 32'd0);
      chk("reacq bin_out", 32'(bin_out), 32'd9);

      // one-cycle reset in the middle of an advancing stream
      cur = 3;
      for (int k = 0; k < 6; k++) begin cyc(gc(cur), 0, 1); cur++; end
      cyc(gc(cur), 0, 0);
      cur++;
      chk("mid rst bin_out", 32'(bin_out), 32'd0);
      chk("mid rst bin_valid", 32'(bin_valid), 32'd0);
      chk("mid rst adv", 32'(adv), 32'd0);
      chk("mid rst err_cnt", 32'(err_cnt), 32'd0);
      cur = 11;
      for (int k = 0; k < LAT; k++) begin cyc(gc(cur), 0, 1); cur++; end
      chk("post rst bin_valid", 32'(bin_valid), 32'd1);
      chk("post rst step_err", 32'(step_err), 32'd0);
      chk("post rst bin_out", 32'(bin_out), 32'd11);

      // random stream: mostly advancing, some holds, jumps, clears and resets
      for (int k = 0; k < 600; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70) cur = (cur + 1) % MOD;
         else if (r < 85) cur = cur;
         else cur = int'($urandom_range(0, MOD - 1));
         cyc(gc(cur), ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
